// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
// Instruction-fetch stage: program counter register, instruction-memory
// request/handshake, a one-entry hold buffer for instructions fetched while
// stalled, and the IF/ID pipeline register.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   defined   -> a misaligned next PC sets the sticky pc_misaligned flag and
//                parks the stage in HALT until reset.
//   undefined -> low PC bits are silently cleared and pc_misaligned is 0.
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        pc_misaligned
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        misaligned_q, misaligned_d;
    logic        imem_req_s;
    logic        accept_s;
    logic        load_pc_s;

    // Word-align a PC: instructions live on 4-byte boundaries.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    // State register: all stage flops, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            hold_pc_q     <= 32'h0000_0000;
            hold_instr_q  <= NOP_INSTR;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            hold_pc_q     <= hold_pc_d;
            hold_instr_q  <= hold_instr_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Next-state logic: handshake, stall/flush priority, PC load and alignment.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        hold_pc_d     = hold_pc_q;
        hold_instr_d  = hold_instr_q;
        misaligned_d  = misaligned_q;
        load_pc_s     = 1'b0;
        accept_s      = imem_req_s & imem_ready;

        case (state_q)
            ST_HALT: begin
                // PC frozen; a flush may still squash the IF/ID slot.
                if (flush) begin
                    if_id_pc_d    = 32'h0000_0000;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else begin
                    if_id_valid_d = if_id_valid_q;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    if_id_pc_d    = 32'h0000_0000;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    load_pc_s     = 1'b1;
                    state_d       = ST_FETCH;
                end else if (!stall) begin
                    if_id_pc_d    = hold_pc_q;
                    if_id_instr_d = hold_instr_q;
                    if_id_valid_d = 1'b1;
                    load_pc_s     = 1'b1;
                    state_d       = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FETCH: begin
                if (flush) begin
                    // Any data returned this cycle is dropped.
                    if_id_pc_d    = 32'h0000_0000;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    load_pc_s     = 1'b1;
                end else if (accept_s && stall) begin
                    // Park the returned word so it is not lost during the stall.
                    hold_pc_d    = pc_q;
                    hold_instr_d = imem_rdata;
                    state_d      = ST_HOLD;
                end else if (accept_s) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    load_pc_s     = 1'b1;
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                end else begin
                    if_id_valid_d = if_id_valid_q;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (load_pc_s) begin
            pc_d = align_pc(next_pc_in);
`ifdef PC_ALIGN_CHECK_EN
            if (next_pc_in[1:0] != 2'b00) begin
                misaligned_d = 1'b1;
                state_d      = ST_HALT;
            end else begin
                misaligned_d = misaligned_q;
            end
`endif
        end else begin
            pc_d = pc_q;
        end
    end

    // Output logic: request is a pure function of state.
    always_comb begin
        case (state_q)
            ST_FETCH: imem_req_s = 1'b1;
            ST_HOLD:  imem_req_s = 1'b0;
            ST_HALT:  imem_req_s = 1'b0;
            default:  imem_req_s = 1'b0;
        endcase
    end

    assign imem_req    = imem_req_s;
    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
`ifdef PC_ALIGN_CHECK_EN
    assign pc_misaligned = misaligned_q;
`else
    assign pc_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_stage
// Directed scenarios followed by randomized stimulus, all checked against a
// transaction-level reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc_in;
    logic        stall;
    logic        flush;
    logic [31:0] pc_out;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        pc_misaligned;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model state (what the stage should hold after each edge).
    logic [31:0] m_pc;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_ifid_valid;
    bit          m_buffered;
    logic [31:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    bit          m_halted;
    bit          m_mis;

    pc_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .next_pc_in    (next_pc_in),
        .stall         (stall),
        .flush         (flush),
        .pc_out        (pc_out),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .pc_misaligned (pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input bit r, input bit st, input bit fl, input bit rdy,
                              input logic [31:0] rd, input logic [31:0] np);
        bit loaded;
        loaded = 1'b0;
        if (r) begin
            m_pc = RESET_PC; m_ifid_pc = 32'h0; m_ifid_instr = NOP_INSTR; m_ifid_valid = 1'b0;
            m_buffered = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
        end else if (m_halted) begin
            if (fl) begin
                m_ifid_pc = 32'h0; m_ifid_instr = NOP_INSTR; m_ifid_valid = 1'b0;
            end
        end else begin
            if (fl) begin
                m_ifid_pc = 32'h0; m_ifid_instr = NOP_INSTR; m_ifid_valid = 1'b0;
                m_buffered = 1'b0; loaded = 1'b1;
            end else if (m_buffered) begin
                if (!st) begin
                    m_ifid_pc = m_buf_pc; m_ifid_instr = m_buf_instr; m_ifid_valid = 1'b1;
                    m_buffered = 1'b0; loaded = 1'b1;
                end
            end else if (rdy) begin
                if (st) begin
                    m_buf_pc = m_pc; m_buf_instr = rd; m_buffered = 1'b1;
                end else begin
                    m_ifid_pc = m_pc; m_ifid_instr = rd; m_ifid_valid = 1'b1; loaded = 1'b1;
                end
            end else if (!st) begin
                m_ifid_valid = 1'b0;
            end
            if (loaded) begin
                m_pc = np & 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
                if ((np % 32'd4) != 32'd0) begin
                    m_mis = 1'b1;
                    m_halted = 1'b1;
                end
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, step the model, and compare every output.
    task automatic cycle(input bit r, input bit st, input bit fl, input bit rdy,
                         input logic [31:0] rd, input logic [31:0] np);
        @(negedge clk);
        reset = r; stall = st; flush = fl; imem_ready = rdy; imem_rdata = rd; next_pc_in = np;
        model_step(r, st, fl, rdy, rd, np);
        @(posedge clk);
        #1;
        check_eq("pc_out",      pc_out,                 m_pc);
        check_eq("imem_addr",   imem_addr,              m_pc);
        check_eq("imem_req",    {31'd0, imem_req},      {31'd0, !(m_buffered || m_halted)});
        check_eq("if_id_pc",    if_id_pc,               m_ifid_pc);
        check_eq("if_id_instr", if_id_instr,            m_ifid_instr);
        check_eq("if_id_valid", {31'd0, if_id_valid},   {31'd0, m_ifid_valid});
        check_eq("misaligned",  {31'd0, pc_misaligned}, {31'd0, m_mis});
    endtask

    initial begin
        logic [31:0] np;
        int          sel;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        imem_rdata = 32'h0; next_pc_in = 32'h0;
        m_pc = RESET_PC; m_ifid_pc = 32'h0; m_ifid_instr = NOP_INSTR; m_ifid_valid = 1'b0;
        m_buffered = 1'b0; m_buf_pc = 32'h0; m_buf_instr = NOP_INSTR; m_halted = 1'b0; m_mis = 1'b0;

        // Reset state.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("rst_pc", pc_out, 32'h0000_0000);
        check_eq("rst_instr", if_id_instr, 32'h0000_0013);

        // Streaming fetch: 0 -> 4 -> 8.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_0001, 32'h0000_0004);
        check_eq("s1_ifid_pc0", if_id_pc, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_0002, 32'h0000_0008);
        check_eq("s1_pc8", pc_out, 32'h0000_0008);
        check_eq("s1_ifid_pc4", if_id_pc, 32'h0000_0004);

        // Stall 3 cycles while fetching pc=8, then release.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h00A0_0093, 32'h0000_000C);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_000C);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_000C);
        check_eq("s2_req_hold", {31'd0, imem_req}, 32'd0);
        check_eq("s2_pc_held", pc_out, 32'h0000_0008);
        check_eq("s2_ifid_old", if_id_pc, 32'h0000_0004);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_000C);
        check_eq("s2_rel_instr", if_id_instr, 32'h00A0_0093);
        check_eq("s2_rel_pc", if_id_pc, 32'h0000_0008);
        check_eq("s2_pc12", pc_out, 32'h0000_000C);

        // Advance to 0x10, then imem not ready for two cycles.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_0003, 32'h0000_0010);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0014);
        check_eq("s3_bubble", {31'd0, if_id_valid}, 32'd0);
        check_eq("s3_pc_held", pc_out, 32'h0000_0010);
        check_eq("s3_req", {31'd0, imem_req}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_0004, 32'h0000_0014);
        check_eq("s3_adv", pc_out, 32'h0000_0014);

        // Enter HOLD, then flush with stall to 0x40.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h4444_0005, 32'h0000_0018);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h4444_0006, 32'h0000_0040);
        check_eq("s4_pc", pc_out, 32'h0000_0040);
        check_eq("s4_instr", if_id_instr, 32'h0000_0013);
        check_eq("s4_req", {31'd0, imem_req}, 32'd1);

        // Reset while stalled in HOLD.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h5555_0007, 32'h0000_0044);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h5555_0008, 32'h0000_0044);
        check_eq("s5_pc", pc_out, RESET_PC);
        check_eq("s5_req", {31'd0, imem_req}, 32'd1);

        // Misaligned next PC, and wrap-around of the top address.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_0009, 32'h0000_0022);
        check_eq("s6_pc", pc_out, 32'h0000_0020);
`ifdef PC_ALIGN_CHECK_EN
        check_eq("s6_flag", {31'd0, pc_misaligned}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_000A, 32'h0000_0024);
        check_eq("s6_halt_req", {31'd0, imem_req}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`else
        check_eq("s6_flag", {31'd0, pc_misaligned}, 32'd0);
        check_eq("s6_req", {31'd0, imem_req}, 32'd1);
`endif
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_000B, 32'h0000_0000);
        check_eq("wrap_pc", pc_out, 32'h0000_0000);
        check_eq("wrap_ifid", if_id_pc, 32'hFFFF_FFFC);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            sel = int'($urandom_range(99, 0));
            if (sel < 70)      np = m_pc + 32'd4;
            else if (sel < 92) np = $urandom() & 32'hFFFF_FFFC;
            else               np = $urandom();
            cycle(($urandom_range(99, 0) < 3),
                  ($urandom_range(99, 0) < 25),
                  ($urandom_range(99, 0) < 8),
                  ($urandom_range(99, 0) < 70),
                  $urandom(), np);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
